uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter that shares one UART transmitter among NREQ requesters.

---
 rtl/uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter sharing one UART transmitter among NREQ requesters.
// The owner keeps the link until its last word; a mid-message stall of MAX_GAP cycles drops the grant.
module uart_tx_arbiter #(
    parameter int WL      = 8,
    parameter int NREQ    = 4,
    parameter int MAX_GAP = 1024,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ*WL-1:0] req_word,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ack,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               abort_pulse,
    output logic               tx_data_vld,
    output logic [WL-1:0]      tx_word,
    input  logic               tx_data_rdy
);

    localparam int GW1 = GW + 1;
    localparam int GCW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [GW-1:0]      rr_ptr_r, rr_nxt_s;
    logic [GCW-1:0]     gap_cnt_r, gap_nxt_s;
    logic [WL-1:0]      word_r, word_nxt_s;
    logic               last_r, last_nxt_s;
    logic [NREQ-1:0]    req_ack_r, ack_nxt_s;
    logic [GW-1:0]      grant_r, grant_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               abort_r, abort_nxt_s;
    logic               tx_vld_r, tx_vld_nxt_s;

    logic [GW-1:0]      pick_s;
    logic [GW-1:0]      cap_idx_s;
    logic [WL-1:0]      cap_word_s;
    logic               cap_last_s;
    logic [GW-1:0]      rr_inc_s;

    // Lowest-index requester at or after ptr, wrapping; later (smaller k) hits overwrite earlier ones.
    function automatic logic [GW-1:0] pick_grant(input logic [NREQ-1:0] vld, input logic [GW-1:0] ptr);
        logic [GW-1:0] sel;
        logic [GW:0]   idx;
        sel = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + GW1'(k);
            idx = (idx >= GW1'(NREQ)) ? idx - GW1'(NREQ) : idx;
            sel = vld[idx[GW-1:0]] ? idx[GW-1:0] : sel;
        end
        return sel;
    endfunction

    assign pick_s     = pick_grant(req_vld, rr_ptr_r);
    assign cap_idx_s  = (state_r == ST_HOLD) ? grant_r : pick_s;
    assign cap_word_s = req_word[int'(cap_idx_s) * WL +: WL];
    assign cap_last_s = req_last[cap_idx_s];
    assign rr_inc_s   = (grant_r == GW'(NREQ - 1)) ? {GW{1'b0}} : grant_r + GW'(1);

    // Next-state and next-output logic for the message FSM
    always_comb begin
        state_nxt_s  = state_r;
        rr_nxt_s     = rr_ptr_r;
        gap_nxt_s    = gap_cnt_r;
        word_nxt_s   = word_r;
        last_nxt_s   = last_r;
        ack_nxt_s    = {NREQ{1'b0}};
        grant_nxt_s  = grant_r;
        busy_nxt_s   = busy_r;
        abort_nxt_s  = 1'b0;
        tx_vld_nxt_s = tx_vld_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_vld) begin
                    grant_nxt_s          = pick_s;
                    word_nxt_s           = cap_word_s;
                    last_nxt_s           = cap_last_s;
                    ack_nxt_s[cap_idx_s] = 1'b1;
                    busy_nxt_s           = 1'b1;
                    tx_vld_nxt_s         = 1'b1;
                    state_nxt_s          = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Transmitter lowering data_rdy is its acceptance of the word.
                if (!tx_data_rdy) begin
                    tx_vld_nxt_s = 1'b0;
                    state_nxt_s  = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DRAIN: begin
                if (tx_data_rdy) begin
                    if (last_r) begin
                        rr_nxt_s    = rr_inc_s;
                        busy_nxt_s  = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        gap_nxt_s   = {GCW{1'b0}};
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (req_vld[grant_r]) begin
                    word_nxt_s           = cap_word_s;
                    last_nxt_s           = cap_last_s;
                    ack_nxt_s[cap_idx_s] = 1'b1;
                    tx_vld_nxt_s         = 1'b1;
                    state_nxt_s          = ST_SEND;
                end else if (gap_cnt_r == GCW'(MAX_GAP - 1)) begin
                    abort_nxt_s = 1'b1;
                    rr_nxt_s    = rr_inc_s;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s   = gap_cnt_r + GCW'(1);
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, word latch and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= {GW{1'b0}};
            gap_cnt_r <= {GCW{1'b0}};
            word_r    <= {WL{1'b0}};
            last_r    <= 1'b0;
            req_ack_r <= {NREQ{1'b0}};
            grant_r   <= {GW{1'b0}};
            busy_r    <= 1'b0;
            abort_r   <= 1'b0;
            tx_vld_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rr_ptr_r  <= rr_nxt_s;
            gap_cnt_r <= gap_nxt_s;
            word_r    <= word_nxt_s;
            last_r    <= last_nxt_s;
            req_ack_r <= ack_nxt_s;
            grant_r   <= grant_nxt_s;
            busy_r    <= busy_nxt_s;
            abort_r   <= abort_nxt_s;
            tx_vld_r  <= tx_vld_nxt_s;
        end
    end

    assign req_ack     = req_ack_r;
    assign grant_id    = grant_r;
    assign busy        = busy_r;
    assign abort_pulse = abort_r;
    assign tx_data_vld = tx_vld_r;
    assign tx_word     = word_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a UART transmitter model and a
// message-level round-robin reference model that predicts the transmitted word stream.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MG = 16;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [N-1:0] req_vld, req_last, req_ack;
    logic [N*8-1:0] req_word;
    logic [1:0]   grant_id;
    logic         busy, abort_pulse, tx_data_vld, tx_data_rdy;
    logic [7:0]   tx_word;

    uart_tx_arbiter #(.WL(8), .NREQ(N), .MAX_GAP(MG)) dut (
        .CLK(CLK), .RST_N(RST_N), .req_vld(req_vld), .req_word(req_word), .req_last(req_last),
        .req_ack(req_ack), .grant_id(grant_id), .busy(busy), .abort_pulse(abort_pulse),
        .tx_data_vld(tx_data_vld), .tx_word(tx_word), .tx_data_rdy(tx_data_rdy)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0;
    logic [8:0] mq [N][32];
    int hd [N], tl [N], mh [N];
    int mptr;
    logic [7:0] exp_w[$], obs_w[$];
    int exp_g[$], obs_g[$];
    int exp_abort, abort_cnt, abort_gap, last_rise_cyc, ack_total, words_loaded, cnt;
    logic prev_vld;
    logic [7:0] prev_word;
    bit force_all;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (force_all) begin
                req_vld[i] = 1'b1; req_last[i] = 1'b1; req_word[i*8 +: 8] = 8'hFF;
            end else if (hd[i] < tl[i]) begin
                req_vld[i] = 1'b1; req_last[i] = mq[i][hd[i]][8]; req_word[i*8 +: 8] = mq[i][hd[i]][7:0];
            end else begin
                req_vld[i] = 1'b0; req_last[i] = 1'b0; req_word[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    // One clock: UART model, protocol checks, ack bookkeeping, requester redrive.
    task automatic tick();
        @(negedge CLK);
        cyc++;
        if (!RST_N) begin
            tx_data_rdy = 1'b1; cnt = 0; prev_vld = 1'b0;
        end else begin
            if (!tx_data_rdy) chk("vld_drop_after_rdy_low", 32'(tx_data_vld), 32'd0);
            if (tx_data_vld && prev_vld) chk("tx_word_stable", 32'(tx_word), 32'(prev_word));
            prev_vld = tx_data_vld; prev_word = tx_word;
            if (tx_data_rdy && tx_data_vld) begin
                obs_w.push_back(tx_word); obs_g.push_back(int'(grant_id));
                tx_data_rdy = 1'b0; cnt = int'($urandom_range(5, 2));
            end else if (!tx_data_rdy) begin
                cnt--;
                if (cnt == 0) begin tx_data_rdy = 1'b1; last_rise_cyc = cyc; end
            end
            if (abort_pulse) begin abort_cnt++; abort_gap = cyc - last_rise_cyc; end
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    ack_total++;
                    chk("ack_owner", 32'(grant_id), 32'(i));
                    chk("ack_pending", 32'(hd[i] < tl[i]), 32'd1);
                    if (hd[i] < tl[i]) hd[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic load(input int i, input logic [7:0] w, input logic l);
        mq[i][tl[i]] = {l, w}; tl[i]++; words_loaded++;
        drive();
    endtask

    // Message-level round robin: whole messages, pointer moves past each finished/aborted owner.
    task automatic model_run();
        int g; bit found; logic [8:0] e;
        while (1) begin
            found = 1'b0; g = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && mh[(mptr + k) % N] < tl[(mptr + k) % N]) begin
                    g = (mptr + k) % N; found = 1'b1;
                end
            end
            if (!found) break;
            do begin
                e = mq[g][mh[g]]; mh[g]++;
                exp_w.push_back(e[7:0]); exp_g.push_back(g);
            end while (!e[8] && mh[g] < tl[g]);
            if (!e[8]) exp_abort++;
            mptr = (g + 1) % N;
        end
    endtask

    task automatic clear_phase();
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; mh[i] = 0; end
        exp_w.delete(); obs_w.delete(); exp_g.delete(); obs_g.delete();
        exp_abort = 0; abort_cnt = 0; ack_total = 0; words_loaded = 0;
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            tick(); n++;
            done = !busy && tx_data_rdy && !tx_data_vld;
            for (int i = 0; i < N; i++) if (hd[i] < tl[i]) done = 1'b0;
        end
        chk({tag, "_finished_in_budget"}, 32'(done), 32'd1);
    endtask

    task automatic wait_hd(input int i, input int target, input int budget);
        int n = 0;
        while (hd[i] < target && n < budget) begin tick(); n++; end
        chk("ack_in_budget", 32'(hd[i] >= target), 32'd1);
    endtask

    task automatic compare_phase(input string tag);
        chk({tag, "_word_count"}, 32'(obs_w.size()), 32'(exp_w.size()));
        for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++) begin
            chk({tag, "_tx_word"}, 32'(obs_w[k]), 32'(exp_w[k]));
            chk({tag, "_grant"}, 32'(obs_g[k]), 32'(exp_g[k]));
        end
        chk({tag, "_aborts"}, 32'(abort_cnt), 32'(exp_abort));
        chk({tag, "_acks"}, 32'(ack_total), 32'(words_loaded));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_grant"}, 32'(grant_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort"}, 32'(abort_pulse), 32'd0);
        chk({tag, "_tx_vld"}, 32'(tx_data_vld), 32'd0);
        chk({tag, "_tx_word"}, 32'(tx_word), 32'd0);
    endtask

    initial begin
        int n;
        RST_N = 1'b0; force_all = 1'b1; tx_data_rdy = 1'b1; mptr = 0;
        prev_vld = 1'b0; prev_word = 8'h00; cnt = 0; last_rise_cyc = 0; abort_gap = 0;
        clear_phase();
        tick(); tick();
        check_zero("reset");
        RST_N = 1'b1; force_all = 1'b0; drive();

        // All four request single-word messages, requester 0 twice.
        clear_phase();
        for (int i = 0; i < N; i++) load(i, 8'(8'hA0 + i), 1'b1);
        load(0, 8'hA0, 1'b1);
        model_run();
        wait_done("rr", 2000);
        compare_phase("rr");

        // Multi-word message from 2 is not interrupted by 0/1 waiting.
        clear_phase();
        load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
        model_run();
        wait_hd(2, 1, 200);
        load(0, 8'($urandom), 1'b1); load(1, 8'($urandom), 1'b1);
        if ($urandom_range(1, 0) == 1) load(3, 8'($urandom), 1'b1);
        model_run();
        wait_done("multi", 2000);
        compare_phase("multi");

        // Requester 1 stalls after one non-last word: timeout, then grant passes to 2.
        clear_phase();
        load(1, 8'h55, 1'b0);
        model_run();
        wait_hd(1, 1, 200);
        load(0, 8'($urandom), 1'b1); load(2, 8'($urandom), 1'b1); load(3, 8'($urandom), 1'b1);
        model_run();
        wait_done("abort", 2000);
        compare_phase("abort");
        chk("abort_gap", 32'(abort_gap), 32'(MG + 1));

        // Randomized message mixes.
        for (int r = 0; r < 4; r++) begin
            clear_phase();
            for (int i = 0; i < N; i++) begin
                int msgs = int'($urandom_range(3, 0));
                for (int m = 0; m < msgs; m++) begin
                    int len = int'($urandom_range(3, 1));
                    for (int w = 0; w < len; w++) load(i, 8'($urandom), (w == len - 1));
                end
            end
            model_run();
            wait_done("random", 3000);
            compare_phase("random");
        end

        // Reset while in SEND.
        clear_phase();
        load(3, 8'h3C, 1'b0); load(3, 8'h3D, 1'b1);
        n = 0;
        while (!tx_data_vld && n < 100) begin tick(); n++; end
        chk("reached_send", 32'(tx_data_vld), 32'd1);
        RST_N = 1'b0;
        clear_phase();
        tick();
        check_zero("rst_send");
        tick();
        RST_N = 1'b1; mptr = 0;

        // Reset while in HOLD.
        clear_phase();
        load(2, 8'h77, 1'b0);
        wait_hd(2, 1, 200);
        n = 0;
        while (!(obs_w.size() == 1 && tx_data_rdy) && n < 100) begin tick(); n++; end
        tick(); tick(); tick();
        chk("hold_no_abort_yet", 32'(abort_cnt), 32'd0);
        RST_N = 1'b0;
        clear_phase();
        tick();
        check_zero("rst_hold");
        tick();
        RST_N = 1'b1; mptr = 0;
        for (int k = 0; k < MG + 8; k++) tick();
        chk("no_abort_after_rst", 32'(abort_cnt), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Fresh requests after reset start from pointer 0.
        clear_phase();
        for (int i = N - 1; i >= 0; i--) load(i, 8'(8'hC0 + i), 1'b1);
        model_run();
        wait_done("post_rst", 2000);
        compare_phase("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
